// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus_timer peripheral.
//  - Register word indices (addr[1:0]) for the four-register map.
//  - Bit positions of the CTRL and STATUS fields.
//  - ctrl_t: the single-bit CTRL flags. The prescale field is kept as a separate
//    register because its width is a module parameter.
//  - apply_be: merges write data into an old 32-bit value, one byte per byte_enable bit.
package bus_timer_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_RELOAD_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;
  localparam int CTRL_PRESCALE_LSB = 8;

  localparam int STATUS_MATCH_BIT    = 0;
  localparam int STATUS_OVERFLOW_BIT = 1;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic enable;
  } ctrl_t;

  function automatic logic [31:0] apply_be(input logic [31:0] old_value,
                                           input logic [31:0] data,
                                           input logic [3:0]  be);
    logic [31:0] result;
    result = old_value;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) result[8*i +: 8] = data[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Clock prescaler for bus_timer.
//  clk, reset : system clock, synchronous active-high reset
//  enable     : run the prescaler; low holds it at zero
//  prescale   : terminal count; a tick is produced every prescale+1 cycles
//  clear      : restart from zero (used when software rewrites COUNT)
//  tick       : high in the cycle whose rising edge advances the timer
// tick is decoded from flops only, so it has no path from the bus inputs.
module bus_timer_prescaler
  import bus_timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      clear,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] cnt;

  assign tick = enable && (cnt == prescale);

  always_ff @(posedge clk) begin
    if (reset || !enable || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      // If prescale is lowered below cnt, cnt runs on and wraps before ticking.
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer, bus follower.
//  clk, reset              : system clock, synchronous active-high reset
//  leader_addr             : word address, only [1:0] decoded
//  leader_write_data       : write data
//  leader_byte_enable      : per-byte write enable
//  leader_read_req         : read strobe (one request per cycle high)
//  leader_write_req        : write strobe (one request per cycle high)
//  leader_read_data        : read data, zero unless leader_read_data_valid
//  leader_read_data_valid  : pulse one cycle after leader_read_req
//  irq                     : CTRL.irq_en & STATUS.match (level)
// Handshake: there is no back-pressure. A request is accepted at the edge where
// its strobe is high; a read answers with a one-cycle valid pulse at the next
// edge, and a write gets no response.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int          PRESCALE_WIDTH = 8,
  parameter logic [31:0] RESET_COMPARE  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] leader_addr,
  input  logic [31:0] leader_write_data,
  input  logic [3:0]  leader_byte_enable,
  input  logic        leader_read_req,
  input  logic        leader_write_req,
  output logic [31:0] leader_read_data,
  output logic        leader_read_data_valid,
  output logic        irq
);

  localparam int PRESCALE_MSB = CTRL_PRESCALE_LSB + PRESCALE_WIDTH - 1;

  ctrl_t                     ctrl;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [31:0]               count;
  logic [31:0]               compare;
  logic [1:0]                status;

  logic [1:0]  reg_sel;
  logic        wr_ctrl, wr_count, wr_compare, wr_status;
  logic [31:0] ctrl_image, ctrl_new, count_new, compare_new;
  logic [31:0] read_mux;
  logic [31:0] count_ticked;
  logic        tick, at_match, set_match, set_overflow;
  logic [1:0]  w1c_mask;
  logic        unused_bits;

  assign reg_sel    = leader_addr[1:0];
  assign wr_ctrl    = leader_write_req && (reg_sel == REG_CTRL);
  assign wr_count   = leader_write_req && (reg_sel == REG_COUNT);
  assign wr_compare = leader_write_req && (reg_sel == REG_COMPARE);
  assign wr_status  = leader_write_req && (reg_sel == REG_STATUS);

  // Undecoded address bits and the reserved CTRL bits are deliberately dropped.
  assign unused_bits = ^{leader_addr[31:2], ctrl_new[31:PRESCALE_MSB+1],
                         ctrl_new[CTRL_PRESCALE_LSB-1:CTRL_IRQ_EN_BIT+1]};

  always_comb begin
    ctrl_image                                   = '0;
    ctrl_image[CTRL_ENABLE_BIT]                  = ctrl.enable;
    ctrl_image[CTRL_RELOAD_BIT]                  = ctrl.auto_reload;
    ctrl_image[CTRL_IRQ_EN_BIT]                  = ctrl.irq_en;
    ctrl_image[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH] = prescale;
  end

  assign ctrl_new    = apply_be(ctrl_image, leader_write_data, leader_byte_enable);
  assign count_new   = apply_be(count, leader_write_data, leader_byte_enable);
  assign compare_new = apply_be(compare, leader_write_data, leader_byte_enable);

  // A COUNT write restarts the prescale period so the new value lasts a full period.
  bus_timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (ctrl.enable),
    .prescale (prescale),
    .clear    (wr_count),
    .tick     (tick)
  );

  always_comb begin
    at_match     = (count == compare);
    set_match    = tick && at_match;
    // A reload to zero is not a wrap; only a plain increment out of all-ones is.
    set_overflow = tick && !(at_match && ctrl.auto_reload) && (count == 32'hFFFF_FFFF);
    count_ticked = (at_match && ctrl.auto_reload) ? 32'd0 : count + 32'd1;
    w1c_mask     = (wr_status && leader_byte_enable[0]) ? leader_write_data[1:0] : 2'b00;
  end

  always_comb begin
    read_mux = '0;
    case (reg_sel)
      REG_CTRL:    read_mux = ctrl_image;
      REG_COUNT:   read_mux = count;
      REG_COMPARE: read_mux = compare;
      REG_STATUS:  read_mux = {30'd0, status};
      default:     read_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl                   <= '0;
      prescale               <= '0;
      count                  <= '0;
      compare                <= RESET_COMPARE;
      status                 <= '0;
      leader_read_data       <= '0;
      leader_read_data_valid <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl.enable      <= ctrl_new[CTRL_ENABLE_BIT];
        ctrl.auto_reload <= ctrl_new[CTRL_RELOAD_BIT];
        ctrl.irq_en      <= ctrl_new[CTRL_IRQ_EN_BIT];
        prescale         <= ctrl_new[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH];
      end

      if (wr_count) begin
        count <= count_new;
      end else if (tick) begin
        count <= count_ticked;
      end

      if (wr_compare) begin
        compare <= compare_new;
      end

      // Clear first, then OR in hardware events so a same-edge event survives.
      status[STATUS_MATCH_BIT]    <= (status[STATUS_MATCH_BIT] & ~w1c_mask[STATUS_MATCH_BIT])
                                     | set_match;
      status[STATUS_OVERFLOW_BIT] <= (status[STATUS_OVERFLOW_BIT] & ~w1c_mask[STATUS_OVERFLOW_BIT])
                                     | set_overflow;

      // read_mux sees pre-edge register values, so a same-cycle write is not visible.
      leader_read_data_valid <= leader_read_req;
      leader_read_data       <= leader_read_req ? read_mux : 32'd0;
    end
  end

  assign irq = ctrl.irq_en & status[STATUS_MATCH_BIT];

endmodule

// File: tb/tb_bus_timer.sv
module tb_bus_timer;

  localparam logic [1:0] A_CTRL = 2'd0, A_COUNT = 2'd1, A_COMPARE = 2'd2, A_STATUS = 2'd3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] leader_addr;
  logic [31:0] leader_write_data;
  logic [3:0]  leader_byte_enable;
  logic        leader_read_req;
  logic        leader_write_req;
  logic [31:0] leader_read_data;
  logic        leader_read_data_valid;
  logic        irq;

  always #5 clk = ~clk;

  bus_timer dut (
    .clk                    (clk),
    .reset                  (reset),
    .leader_addr            (leader_addr),
    .leader_write_data      (leader_write_data),
    .leader_byte_enable     (leader_byte_enable),
    .leader_read_req        (leader_read_req),
    .leader_write_req       (leader_write_req),
    .leader_read_data       (leader_read_data),
    .leader_read_data_valid (leader_read_data_valid),
    .irq                    (irq)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // Reference state: the register map as software sees it.
  logic [31:0] m_ctrl, m_count, m_compare;
  logic [1:0]  m_status;
  int          m_psc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = {be[3] ? d[31:24] : o[31:24], be[2] ? d[23:16] : o[23:16],
         be[1] ? d[15:8]  : o[15:8],  be[0] ? d[7:0]   : o[7:0]};
    return m;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      A_CTRL:    return m_ctrl;
      A_COUNT:   return m_count;
      A_COMPARE: return m_compare;
      default:   return {30'd0, m_status};
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_count = 0; m_compare = 32'hFFFF_FFFF; m_status = 0; m_psc = 0;
  endtask

  // Advance the reference by one clock edge with the given bus request.
  task automatic model_edge(input bit wr, input logic [1:0] a, input logic [31:0] d,
                            input logic [3:0] be);
    bit          en, tick, reload;
    logic [31:0] next_count;
    logic [1:0]  set;
    en     = m_ctrl[0];
    reload = m_ctrl[1];
    tick   = en && (m_psc == int'(m_ctrl[15:8]));
    next_count = m_count;
    set = 2'b00;
    if (tick) begin
      if (m_count == m_compare) begin
        set[0] = 1'b1;
        next_count = reload ? 32'd0 : m_count + 1;
        if (!reload && m_count == 32'hFFFF_FFFF) set[1] = 1'b1;
      end else begin
        next_count = m_count + 1;
        if (m_count == 32'hFFFF_FFFF) set[1] = 1'b1;
      end
    end
    if (!en || tick) m_psc = 0;
    else m_psc = (m_psc + 1) % 256;
    if (wr) begin
      case (a)
        A_CTRL:    m_ctrl = merge(m_ctrl, d, be) & 32'h0000_FF07;
        A_COUNT:   begin next_count = merge(m_count, d, be); m_psc = 0; end
        A_COMPARE: m_compare = merge(m_compare, d, be);
        default:   if (be[0]) m_status = m_status & ~d[1:0];
      endcase
    end
    m_status = m_status | set;
    m_count  = next_count;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit rst, input bit rd, input bit wr, input logic [1:0] a,
                       input logic [31:0] d, input logic [3:0] be, output logic [31:0] got);
    logic [31:0] r;
    logic [31:0] exp_data;
    bit          exp_valid;
    r = $urandom();
    reset              = rst;
    leader_read_req    = rd;
    leader_write_req   = wr;
    leader_addr        = {r[31:2], a};
    leader_write_data  = d;
    leader_byte_enable = be;
    exp_valid = rd && !rst;
    if (exp_valid) exp_q.push_back(model_read(a));
    if (rst) model_reset();
    else model_edge(wr, a, d, be);
    @(posedge clk);
    #1;
    exp_data = exp_valid ? exp_q.pop_front() : 32'd0;
    check("read_data_valid", {31'd0, leader_read_data_valid}, {31'd0, exp_valid});
    check("read_data", leader_read_data, exp_data);
    check("irq", {31'd0, irq}, {31'd0, m_ctrl[2] & m_status[0]});
    got = leader_read_data;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    logic [31:0] g;
    cycle(0, 0, 1, a, d, be, g);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] got);
    cycle(0, 1, 0, a, 32'd0, 4'h0, got);
  endtask

  task automatic idle(input int n);
    logic [31:0] g;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 2'd0, 32'd0, 4'h0, g);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] got;
    logic [31:0] d;
    logic [1:0]  a;
    bit          r_rd, r_wr, r_rst;

    reset = 1'b1; leader_addr = 0; leader_write_data = 0; leader_byte_enable = 0;
    leader_read_req = 0; leader_write_req = 0;
    model_reset();
    cycle(1, 0, 0, 2'd0, 32'd0, 4'h0, got);
    cycle(1, 0, 0, 2'd0, 32'd0, 4'h0, got);

    // Reset values
    rd(A_CTRL, got);    check("reset_ctrl", got, 32'h0);
    rd(A_COUNT, got);   check("reset_count", got, 32'h0);
    rd(A_COMPARE, got); check("reset_compare", got, 32'hFFFF_FFFF);
    rd(A_STATUS, got);  check("reset_status", got, 32'h0);

    // Free-running count, no prescale, match at 3
    wr(A_COMPARE, 32'd3);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 5; i++) begin
      rd(A_COUNT, got); check("count_seq", got, i);
    end
    rd(A_STATUS, got); check("match_set", got, 32'h1);
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h3);

    // Prescale 3, auto-reload, irq enabled, COMPARE=1
    wr(A_COMPARE, 32'd1);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h0307);
    idle(12);
    check("irq_reload", {31'd0, irq}, 32'd1);
    rd(A_COUNT, got); check("reload_count_small", {31'd0, got > 1}, 32'd0);

    // Overflow wrap
    wr(A_CTRL, 32'h0);
    wr(A_COMPARE, 32'd5);
    wr(A_COUNT, 32'hFFFF_FFFE);
    wr(A_STATUS, 32'h3);
    wr(A_CTRL, 32'h1);
    rd(A_COUNT, got);  check("wrap_fffe", got, 32'hFFFF_FFFE);
    rd(A_COUNT, got);  check("wrap_ffff", got, 32'hFFFF_FFFF);
    rd(A_COUNT, got);  check("wrap_zero", got, 32'h0);
    rd(A_STATUS, got); check("overflow_set", got, 32'h2);
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h2);
    rd(A_STATUS, got); check("overflow_w1c", got, 32'h0);

    // W1C on the same edge as a new match
    wr(A_COMPARE, 32'd0);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h7);
    idle(1);
    wr(A_STATUS, 32'h1);
    check("irq_hold_w1c", {31'd0, irq}, 32'd1);
    rd(A_STATUS, got); check("match_wins", {31'd0, got[0]}, 32'd1);
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h3);

    // Byte-masked write and same-cycle write+read
    wr(A_COMPARE, 32'hFFFF_FFFF);
    wr(A_COMPARE, 32'hAABB_CCDD, 4'b0010);
    rd(A_COMPARE, got); check("byte_write", got, 32'hFFFF_CCFF);
    cycle(0, 1, 1, A_COMPARE, 32'h1234_5678, 4'hF, got);
    check("rw_old_value", got, 32'hFFFF_CCFF);
    rd(A_COMPARE, got); check("rw_new_value", got, 32'h1234_5678);

    // Reserved CTRL bits read as zero
    wr(A_CTRL, 32'hFFFF_FFFF);
    rd(A_CTRL, got); check("ctrl_raz", got, 32'h0000_FF07);
    wr(A_CTRL, 32'h0);

    // Reset while a read response is pending
    rd(A_COUNT, got);
    cycle(1, 0, 0, 2'd0, 32'd0, 4'h0, got);
    check("reset_drop_valid", {31'd0, leader_read_data_valid}, 32'd0);
    cycle(0, 0, 0, 2'd0, 32'd0, 4'h0, got);

    // Randomized traffic against the reference
    for (int i = 0; i < 600; i++) begin
      a     = 2'($urandom_range(0, 3));
      r_rd  = ($urandom_range(0, 1) == 1);
      r_wr  = ($urandom_range(0, 2) == 0);
      r_rst = ($urandom_range(0, 299) == 0);
      case (a)
        A_CTRL:    d = $urandom() & 32'h0000_0307;
        A_COUNT:   d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                    : 32'($urandom_range(0, 20));
        A_COMPARE: d = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 20));
        default:   d = $urandom();
      endcase
      cycle(r_rst, r_rd, r_wr, a, d, 4'($urandom_range(0, 15)), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
